fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
Read-side unloader that sits directly downstream of the async FIFO, in the read clock domain. Pops DSIZE-bit entries from the FIFO's show-ahead read port (rdata valid whenever rempty=0, consumed on the rclk edge with rinc=1). Packs LANES entries into one wide word and presents it on a valid/ready stream to downstream logic. A partial word is emitted on an idle timeout or on an explicit flush request.

Parameters:
DSIZE, 8, width of one FIFO entry (must match the FIFO's DSIZE)
LANES, 4, entries packed per output word (2..16)
TIMEOUT, 16, idle rclk cycles with a partial word before an automatic flush (>=2)

Ports:
rclk  input  1  read-domain clock; all state on posedge
rrst_n  input  1  asynchronous active-low reset
rempty  input  1  FIFO empty flag (read domain)
rdata  input  DSIZE  FIFO head entry; valid when rempty=0
rinc  output  1  FIFO pop strobe (combinational)
flush  input  1  request to emit the current partial word
m_data  output  DSIZE*LANES  packed word; lane 0 in bits [DSIZE-1:0] is the oldest entry
m_keep  output  LANES  per-lane valid mask
m_valid  output  1  output word valid
m_ready  input  1  downstream accept

Behaviour:
- Clock and reset: one clock, rclk; reset rrst_n is asynchronous, active-low.
- Reset values: m_valid=0, m_data=0, m_keep=0, lane count cnt=0, accumulator=0, idle counter=0, flush_pend=0. rinc=0 while rrst_n=0.
- Reset asserted mid-operation: discards any partial word and any held output word immediately; nothing is emitted after release.
- Output slot free (slot_free): m_valid=0, or m_valid=1 with m_ready=1.
- Output transfer: occurs on an edge with m_valid=1 and m_ready=1. m_data/m_keep stay stable while m_valid=1 and m_ready=0.
- Pop rule: rinc = rrst_n & ~rempty & (cnt!=LANES-1 | slot_free).
  - The FIFO itself blocks pops when empty; this block never pops when rempty=1.
- On a pop, rdata is written into lane cnt of the accumulator, then:
  - If cnt<LANES-1: cnt increments.
  - If cnt==LANES-1: the full word (accumulator with the new lane) loads the output register on the same edge, with m_keep all ones. cnt returns to 0.
  - Latency: last-lane pop at edge k gives m_valid=1 after edge k.
- Back-to-back full words at one pop per cycle, with m_ready held high.
- Idle counter:
  - Clears on any pop and whenever cnt==0.
  - Otherwise increments each cycle, saturating at TIMEOUT-1.
- Flush request:
  - flush=1 with cnt>0 sets flush_pend.
  - flush with cnt==0 is ignored; no empty word is ever emitted.
- Partial emit condition: cnt>0, no pop this cycle, slot_free, and (idle==TIMEOUT-1 or flush_pend or flush).
- Partial emit action:
  - Output register loads the accumulator with lanes >=cnt zeroed.
  - m_keep = (1<<cnt)-1.
  - cnt, idle and flush_pend clear.
- Pop vs flush priority: a pop in the same cycle takes priority over a partial emit. The byte is appended and flush_pend stays set, so the flush applies on the next non-pop cycle. This keeps byte order intact.
- Accumulator lanes are not cleared on a full-word emit; zero-fill applies to partial emits only.
- FSM, tracked by cnt and m_valid:
  - EMPTY (cnt=0) -> FILL on pop.
  - FILL -> EMPTY on full-word or partial emit.
  - Output register states are HOLD (m_valid=1) and FREE.
- Ordering: entries appear on m_data in exact FIFO pop order. No entry is lost or duplicated.

Test Plan:
- FIFO holds 01..08, m_ready=1 -> rinc high 8 consecutive cycles; words 0x04030201 then 0x08070605, m_keep=0xF, m_valid one cycle each.
- Backpressure: FIFO holds 01..0C, m_ready=0 -> 0x04030201 held stable; 05,06,07 popped; rinc=0 with rempty=0. After m_ready=1: 0x08070605 then 0x0C0B0A09, no loss.
- Timeout: AA,BB,CC then FIFO empty, m_ready=1 -> exactly 16 cycles after the CC pop, m_data=0x00CCBBAA, m_keep=0x7; cnt returns to 0.
- Flush: 11,22 popped then flush pulse -> next edge m_data=0x00002211, m_keep=0x3. Flush pulse with cnt=0 -> m_valid stays 0.
- Pop on the timeout cycle: entry arrives when idle==TIMEOUT-1 -> no emit that cycle, cnt increments, idle restarts.
- Reset mid-stream: cnt=2 and m_valid=1, assert rrst_n=0 -> m_valid, m_keep and rinc drop immediately. After release with FIFO empty, no output for more than TIMEOUT cycles.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side unloader for the async FIFO (read clock domain).
// Pops entries from the FIFO's show-ahead port, packs LANES of them into one
// wide word (lane 0 = oldest) and emits it on a valid/ready stream. A partial
// word is emitted after TIMEOUT idle cycles or on a flush request.
//
// Handshake: m_valid/m_data/m_keep come straight from registers. Once m_valid
// is high it stays high, with m_data/m_keep stable, until a cycle in which
// m_ready is also high. A word transfers on every rclk edge where
// m_valid & m_ready. m_ready may be asserted independently of m_valid.
// On the FIFO side, rinc is a combinational pop strobe, never asserted while
// rempty is high, and rdata is consumed on the edge where rinc is high.
module fifo_rd_packer #(
  parameter int DSIZE   = 8,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  input  logic                   flush,
  output logic [DSIZE*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int W  = DSIZE * LANES;
  localparam int CW = $clog2(LANES);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST     = CW'(LANES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  // Packing state: EMPTY when no lane is filled, FILL otherwise.
  typedef enum logic {FILL_EMPTY = 1'b0, FILL_ACTIVE = 1'b1} fill_state_e;
  // Output register state: HOLD while a word waits for m_ready.
  typedef enum logic {OUT_FREE = 1'b0, OUT_HOLD = 1'b1} out_state_e;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             fpend_q, fpend_d;
  logic             m_valid_q, m_valid_d;
  logic [W-1:0]     m_data_q, m_data_d;
  logic [LANES-1:0] m_keep_q, m_keep_d;

  logic             slot_free;
  logic             last_pop;
  logic             part_emit;
  logic [W-1:0]     full_word;
  logic [W-1:0]     part_word;
  logic [LANES-1:0] part_keep;

  // State visibility for checkers; derived purely from the registers.
  fill_state_e fill_state;
  out_state_e  out_state;
  assign fill_state = (cnt_q == '0) ? FILL_EMPTY : FILL_ACTIVE;
  assign out_state  = m_valid_q ? OUT_HOLD : OUT_FREE;

  // State register: async active-low reset drops everything immediately.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      idle_q    <= '0;
      fpend_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      idle_q    <= idle_d;
      fpend_q   <= fpend_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
    end
  end

  // Output/decision logic: pop strobe and emit conditions. The last lane is
  // only popped when the output register can take the completed word; a pop
  // always wins over a partial emit so byte order is preserved.
  always_comb begin
    slot_free = ~m_valid_q | m_ready;
    rinc      = rrst_n & ~rempty & ((cnt_q != LAST) | slot_free);
    last_pop  = rinc & (cnt_q == LAST);
    part_emit = (cnt_q != '0) & ~rinc & slot_free &
                ((idle_q == IDLE_MAX) | fpend_q | flush);
  end

  // Next-state logic: lane write, counters, flush latch and output register.
  always_comb begin
    acc_d     = acc_q;
    full_word = acc_q;
    part_word = '0;
    part_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rinc && (cnt_q == CW'(i))) begin
        acc_d[i*DSIZE +: DSIZE] = rdata;
      end
      // Partial words expose only the filled lanes; the rest read as zero.
      if (CW'(i) < cnt_q) begin
        part_word[i*DSIZE +: DSIZE] = acc_q[i*DSIZE +: DSIZE];
        part_keep[i]                = 1'b1;
      end
    end
    full_word[W-1 -: DSIZE] = rdata;

    // Lane count
    if (rinc) begin
      cnt_d = last_pop ? '0 : cnt_q + CW'(1);
    end else if (part_emit) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q;
    end

    // Idle counter: runs only while a partial word sits unpopped.
    if (rinc || part_emit || (cnt_q == '0)) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IW'(1);
    end else begin
      idle_d = idle_q;
    end

    // Flush latch: remembers a request that a same-cycle pop deferred.
    if (part_emit) begin
      fpend_d = 1'b0;
    end else begin
      fpend_d = fpend_q | (flush & (cnt_q != '0));
    end

    // Output register
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    if (last_pop) begin
      m_valid_d = 1'b1;
      m_data_d  = full_word;
      m_keep_d  = '1;
    end else if (part_emit) begin
      m_valid_d = 1'b1;
      m_data_d  = part_word;
      m_keep_d  = part_keep;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed and randomized checks of fifo_rd_packer against
// a queue-based reference model of the FIFO, the lane packing and the stream.
module tb_fifo_rd_packer;

  localparam int DSIZE   = 8;
  localparam int LANES   = 4;
  localparam int TIMEOUT = 16;
  localparam int W       = DSIZE * LANES;

  // ---------------- clock / reset / DUT ----------------
  logic             rclk = 1'b0;
  logic             rrst_n;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             flush;
  logic [W-1:0]     m_data;
  logic [LANES-1:0] m_keep;
  logic             m_valid;
  logic             m_ready;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.DSIZE(DSIZE), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .flush   (flush),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  // ---------------- reference model state ----------------
  int vectors     = 0;
  int miscompares = 0;

  logic [DSIZE-1:0]   fifo_q[$];   // FIFO contents seen by the DUT
  logic [DSIZE-1:0]   sent_q[$];   // every byte not yet seen on the stream
  logic [DSIZE-1:0]   acc[$];      // bytes popped but not yet emitted
  logic [W+LANES-1:0] exp_q[$];    // words the model has emitted {keep,data}
  logic [W-1:0]       got_q[$];    // words the DUT transferred

  int               mdl_idle;
  bit               mdl_fpend;
  bit               mdl_valid;
  logic [W-1:0]     mdl_data;
  logic [LANES-1:0] mdl_keep;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_acc();
    logic [W-1:0] w;
    w = '0;
    foreach (acc[i]) w[i*DSIZE +: DSIZE] = acc[i];
    return w;
  endfunction

  task automatic mdl_reset();
    acc.delete();
    fifo_q.delete();
    sent_q.delete();
    exp_q.delete();
    mdl_idle  = 0;
    mdl_fpend = 0;
    mdl_valid = 0;
    mdl_data  = '0;
    mdl_keep  = '0;
  endtask

  task automatic push(input logic [DSIZE-1:0] b);
    fifo_q.push_back(b);
    sent_q.push_back(b);
  endtask

  // ---------------- driver + model: one rclk cycle ----------------
  // Entered at posedge+1, leaves at the next posedge+1.
  task automatic step(input bit fl_req, input bit rdy);
    bit                 exp_rinc, slot_free, xfer, fl, dut_xv;
    int                 cnt;
    logic [DSIZE-1:0]   b;
    logic [W-1:0]       dd;
    logic [LANES-1:0]   dk;
    logic [W+LANES-1:0] e;
    cnt       = acc.size();
    slot_free = !mdl_valid || rdy;
    exp_rinc  = (fifo_q.size() != 0) && ((cnt != LANES - 1) || slot_free);
    // Keep flush away from cycles that complete a full word.
    fl = fl_req && !(exp_rinc && cnt == LANES - 1);
    rempty  = (fifo_q.size() == 0);
    rdata   = rempty ? DSIZE'($urandom) : fifo_q[0];
    flush   = fl;
    m_ready = rdy;
    #1;
    chk("rinc", rinc, exp_rinc);
    dut_xv = m_valid && m_ready;
    dd     = m_data;
    dk     = m_keep;
    @(posedge rclk);
    xfer = mdl_valid && rdy;
    if (exp_rinc) begin
      b = fifo_q.pop_front();
      if (fl && cnt > 0) mdl_fpend = 1;
      acc.push_back(b);
      mdl_idle = 0;
      if (acc.size() == LANES) begin
        mdl_data  = pack_acc();
        mdl_keep  = '1;
        mdl_valid = 1;
        exp_q.push_back({mdl_keep, mdl_data});
        acc.delete();
      end else if (xfer) begin
        mdl_valid = 0;
      end
    end else if (cnt > 0 && slot_free && (mdl_idle == TIMEOUT - 1 || mdl_fpend || fl)) begin
      mdl_data  = pack_acc();
      mdl_keep  = LANES'((1 << cnt) - 1);
      mdl_valid = 1;
      exp_q.push_back({mdl_keep, mdl_data});
      acc.delete();
      mdl_idle  = 0;
      mdl_fpend = 0;
    end else begin
      if (xfer) mdl_valid = 0;
      if (cnt == 0) mdl_idle = 0;
      else if (mdl_idle < TIMEOUT - 1) mdl_idle++;
      if (fl && cnt > 0) mdl_fpend = 1;
    end
    // Scoreboard: words in emit order, bytes in FIFO push order.
    if (dut_xv) begin
      got_q.push_back(dd);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL xfer_unexpected: observed 0x%0h expected no transfer", {dk, dd});
      end else begin
        e = exp_q.pop_front();
        chk("xfer_word", {dk, dd}, e);
      end
      for (int i = 0; i < LANES; i++) begin
        if (dk[i]) begin
          if (sent_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL order_extra: observed 0x%0h expected no byte", dd[i*DSIZE +: DSIZE]);
          end else begin
            chk("order", dd[i*DSIZE +: DSIZE], sent_q.pop_front());
          end
        end
      end
    end
    #1;
    chk("m_valid", m_valid, mdl_valid);
    chk("m_keep", m_keep, mdl_keep);
    chk("m_data", m_data, mdl_data);
  endtask

  task automatic step_until_fifo_empty(input bit rdy);
    int n;
    n = 0;
    while (fifo_q.size() != 0 && n < 64) begin
      step(0, rdy);
      n++;
    end
    chk("fifo_drain_bound", 64'(fifo_q.size()), 0);
  endtask

  task automatic count_to_valid(output int n);
    n = 0;
    while (!m_valid && n < 4 * TIMEOUT) begin
      step(0, 1);
      n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int p_push, p_rdy;
    rrst_n  = 1'b0;
    rempty  = 1'b1;
    rdata   = '0;
    flush   = 1'b0;
    m_ready = 1'b0;
    mdl_reset();
    #3;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rinc", rinc, 0);
    @(posedge rclk);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;

    // Two full words at one pop per cycle
    for (int i = 1; i <= 8; i++) push(DSIZE'(i));
    got_q.delete();
    repeat (12) step(0, 1);
    chk("t1_words", 64'(got_q.size()), 2);
    if (got_q.size() >= 2) begin
      chk("t1_word0", got_q[0], 32'h04030201);
      chk("t1_word1", got_q[1], 32'h08070605);
    end

    // Backpressure
    for (int i = 1; i <= 12; i++) push(DSIZE'(i));
    repeat (10) step(0, 0);
    chk("bp_hold", m_data, 32'h04030201);
    rempty = 1'b0;
    rdata  = fifo_q[0];
    #1;
    chk("bp_rinc_blocked", rinc, 0);
    got_q.delete();
    repeat (12) step(0, 1);
    chk("bp_words", 64'(got_q.size()), 3);
    if (got_q.size() >= 3) begin
      chk("bp_word0", got_q[0], 32'h04030201);
      chk("bp_word1", got_q[1], 32'h08070605);
      chk("bp_word2", got_q[2], 32'h0C0B0A09);
    end

    // Idle timeout
    push(8'hAA); push(8'hBB); push(8'hCC);
    step_until_fifo_empty(1);
    count_to_valid(n);
    chk("timeout_cycles", 64'(n), 16);
    chk("timeout_data", m_data, 32'h00CCBBAA);
    chk("timeout_keep", m_keep, 4'h7);
    step(0, 1);

    // Flush pulse, then flush with nothing buffered
    push(8'h11); push(8'h22);
    step_until_fifo_empty(1);
    step(1, 1);
    chk("flush_valid", m_valid, 1);
    chk("flush_data", m_data, 32'h00002211);
    chk("flush_keep", m_keep, 4'h3);
    step(0, 1);
    step(1, 1);
    chk("flush_empty_valid", m_valid, 0);
    step(0, 1);
    chk("flush_empty_valid2", m_valid, 0);

    // Pop arriving on the timeout cycle
    push(8'h33);
    step_until_fifo_empty(1);
    repeat (TIMEOUT - 1) step(0, 1);
    push(8'h44);
    step(0, 1);
    chk("to_pop_no_emit", m_valid, 0);
    count_to_valid(n);
    chk("to_pop_cycles", 64'(n), 16);
    chk("to_pop_data", m_data, 32'h00004433);
    chk("to_pop_keep", m_keep, 4'h3);
    step(0, 1);

    // Reset mid-stream with a held word and two lanes buffered
    for (int i = 1; i <= 6; i++) push(DSIZE'(i));
    step_until_fifo_empty(0);
    chk("pre_rst_valid", m_valid, 1);
    rempty  = 1'b0;
    rdata   = 8'h07;
    m_ready = 1'b0;
    #1;
    chk("pre_rst_rinc", rinc, 1);
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_rinc", rinc, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_keep", m_keep, 0);
    mdl_reset();
    rempty = 1'b1;
    @(posedge rclk);
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    repeat (TIMEOUT + 4) step(0, 1);
    chk("post_rst_quiet", m_valid, 0);

    // Randomized segments with varying load and backpressure
    for (int s = 0; s < 20; s++) begin
      p_push = $urandom_range(0, 100);
      p_rdy  = $urandom_range(10, 100);
      repeat (150) begin
        if ($urandom_range(0, 99) < p_push && fifo_q.size() < 16) push(DSIZE'($urandom));
        step($urandom_range(0, 29) == 0, $urandom_range(0, 99) < p_rdy);
      end
    end
    repeat (64) step(0, 1);
    chk("drain_bytes", 64'(sent_q.size()), 0);
    chk("drain_words", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
